gb_cart_header: RTL and testbench

GB_CART_HEADER -- requirements
Module: gb_cart_header

---
 rtl/gb_cart_header.sv | 197 +++++++++++++++++++
 tb/tb_gb_cart_header.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cart_header.sv
// Cartridge header scanner: walks ROM bytes 0x0134..0x014D on a simple
// req/ack port, checks the header checksum, captures the type and size fields
// used by the MBC, and reports a held hdr_ok/error verdict with a done pulse.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last verdict and fields
// REQ   | gap cycle, mem_req low; arms the request for the next cycle
// WAIT  | mem_req high with a stable address until mem_ack or timeout
// CHECK | one-cycle verdict on checksum and field support
// FIN   | done pulse, busy low, back to IDLE
module gb_cart_header (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        busy,
  output logic        done,
  output logic        hdr_ok,
  output logic        error,
  output logic [7:0]  cart_type,
  output logic [7:0]  rom_size,
  output logic [7:0]  ram_size,
  output logic        cgb,
  output logic [2:0]  mbc_sel
);

  localparam logic [15:0] ADDR_FIRST = 16'h0134;
  localparam logic [15:0] ADDR_CGB   = 16'h0143;
  localparam logic [15:0] ADDR_TYPE  = 16'h0147;
  localparam logic [15:0] ADDR_ROM   = 16'h0148;
  localparam logic [15:0] ADDR_RAM   = 16'h0149;
  localparam logic [15:0] ADDR_LAST  = 16'h014C;
  localparam logic [15:0] ADDR_CSUM  = 16'h014D;
  // The counter gives up on the cycle its increment would reach 255.
  localparam logic [7:0]  TMO_LAST   = 8'd254;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        sum_ok_q, sum_ok_d;
  logic        hdr_ok_q, hdr_ok_d;
  logic        error_q, error_d;
  logic [7:0]  cart_type_q, cart_type_d;
  logic [7:0]  rom_size_q, rom_size_d;
  logic [7:0]  ram_size_q, ram_size_d;
  logic        cgb_q, cgb_d;

  // Controller select decoded from the captured cartridge type byte.
  always_comb begin
    mbc_sel = 3'd7;
    if (cart_type_q == 8'h00)                             mbc_sel = 3'd0;
    else if (cart_type_q >= 8'h01 && cart_type_q <= 8'h03) mbc_sel = 3'd1;
    else if (cart_type_q >= 8'h05 && cart_type_q <= 8'h06) mbc_sel = 3'd2;
    else if (cart_type_q >= 8'h0F && cart_type_q <= 8'h13) mbc_sel = 3'd3;
    else if (cart_type_q >= 8'h19 && cart_type_q <= 8'h1E) mbc_sel = 3'd5;
  end

  // Next-state, request handshake, checksum accumulation and field capture.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    tmo_d       = tmo_q;
    sum_ok_d    = sum_ok_q;
    hdr_ok_d    = hdr_ok_q;
    error_d     = error_q;
    cart_type_d = cart_type_q;
    rom_size_d  = rom_size_q;
    ram_size_d  = ram_size_q;
    cgb_d       = cgb_q;

    case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (start) begin
          hdr_ok_d    = 1'b0;
          error_d     = 1'b0;
          sum_ok_d    = 1'b0;
          cart_type_d = 8'h00;
          rom_size_d  = 8'h00;
          ram_size_d  = 8'h00;
          cgb_d       = 1'b0;
          acc_d       = 8'h00;
          addr_d      = ADDR_FIRST;
          state_d     = REQ;
        end
      end
      REQ: begin
        // mem_req is registered, so it rises on entry to WAIT; this leaves
        // the REQ cycle as the low gap between consecutive requests.
        mem_req_d = 1'b1;
        tmo_d     = 8'd0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (addr_q == ADDR_CSUM) begin
            sum_ok_d = (mem_data == acc_q);
            state_d  = CHECK;
          end else begin
            if (addr_q >= ADDR_FIRST && addr_q <= ADDR_LAST)
              acc_d = acc_q - mem_data - 8'd1;
            if (addr_q == ADDR_CGB)  cgb_d       = mem_data[7];
            if (addr_q == ADDR_TYPE) cart_type_d = mem_data;
            if (addr_q == ADDR_ROM)  rom_size_d  = mem_data;
            if (addr_q == ADDR_RAM)  ram_size_d  = mem_data;
            addr_d  = addr_q + 16'd1;
            state_d = REQ;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == TMO_LAST) begin
            mem_req_d = 1'b0;
            error_d   = 1'b1;
            state_d   = FIN;
          end
        end
      end
      CHECK: begin
        if (sum_ok_q && rom_size_q <= 8'h08 && ram_size_q <= 8'h05 &&
            mbc_sel != 3'd7)
          hdr_ok_d = 1'b1;
        else
          error_d = 1'b1;
        state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      addr_q      <= 16'h0000;
      acc_q       <= 8'h00;
      tmo_q       <= 8'h00;
      sum_ok_q    <= 1'b0;
      hdr_ok_q    <= 1'b0;
      error_q     <= 1'b0;
      cart_type_q <= 8'h00;
      rom_size_q  <= 8'h00;
      ram_size_q  <= 8'h00;
      cgb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      addr_q      <= addr_d;
      acc_q       <= acc_d;
      tmo_q       <= tmo_d;
      sum_ok_q    <= sum_ok_d;
      hdr_ok_q    <= hdr_ok_d;
      error_q     <= error_d;
      cart_type_q <= cart_type_d;
      rom_size_q  <= rom_size_d;
      ram_size_q  <= ram_size_d;
      cgb_q       <= cgb_d;
    end
  end

  // Output mapping; busy and done decode directly from the state register.
  always_comb begin
    mem_req   = mem_req_q;
    mem_addr  = {8'h00, addr_q};
    busy      = (state_q == REQ) || (state_q == WAIT) || (state_q == CHECK);
    done      = (state_q == FIN);
    hdr_ok    = hdr_ok_q;
    error     = error_q;
    cart_type = cart_type_q;
    rom_size  = rom_size_q;
    ram_size  = ram_size_q;
    cgb       = cgb_q;
  end

endmodule

// File: tb/tb_gb_cart_header.sv
// Bench for gb_cart_header: a ROM responder with configurable ack latency,
// an address scoreboard and a verdict scoreboard popped on each done pulse.
module tb_gb_cart_header;

  logic        clock;
  logic        rst;
  logic        start;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
  logic        hdr_ok;
  logic        error;
  logic [7:0]  cart_type;
  logic [7:0]  rom_size;
  logic [7:0]  ram_size;
  logic        cgb;
  logic [2:0]  mbc_sel;

  gb_cart_header dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .hdr_ok    (hdr_ok),
    .error     (error),
    .cart_type (cart_type),
    .rom_size  (rom_size),
    .ram_size  (ram_size),
    .cgb       (cgb),
    .mbc_sel   (mbc_sel)
  );

  typedef struct {
    logic       hdr_ok;
    logic       error;
    logic [7:0] cart;
    logic [7:0] rom;
    logic [7:0] ram;
    logic       cgb;
    logic [2:0] mbc;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic [7:0]  img [0:511];
  logic [15:0] exp_addr_q [$];
  exp_t        res_q [$];
  int          lat_min = 0;
  int          lat_max = 0;
  logic [15:0] withhold_addr = 16'hFFFF;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] ref_mbc(input logic [7:0] t);
    if (t == 8'h00) return 3'd0;
    if (t >= 8'h01 && t <= 8'h03) return 3'd1;
    if (t >= 8'h05 && t <= 8'h06) return 3'd2;
    if (t >= 8'h0F && t <= 8'h13) return 3'd3;
    if (t >= 8'h19 && t <= 8'h1E) return 3'd5;
    return 3'd7;
  endfunction

  task automatic build_img(input logic [7:0] ct, input logic [7:0] rom,
                           input logic [7:0] ram, input logic [7:0] b143,
                           input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    for (int a = 'h134; a <= 'h14C; a++) img[a] = 8'($urandom);
    img['h143] = b143;
    img['h147] = ct;
    img['h148] = rom;
    img['h149] = ram;
    for (int a = 'h134; a <= 'h14C; a++) x = x - img[a] - 8'd1;
    img['h14D] = corrupt ? (x ^ 8'h01) : x;
  endtask

  function automatic exp_t exp_from_img(input bit ok);
    exp_t r;
    r.hdr_ok = ok;
    r.error  = !ok;
    r.cart   = img['h147];
    r.rom    = img['h148];
    r.ram    = img['h149];
    r.cgb    = img['h143][7];
    r.mbc    = ref_mbc(img['h147]);
    return r;
  endfunction

  task automatic push_seq(input int last);
    for (int a = 'h134; a <= last; a++) exp_addr_q.push_back(16'(a));
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit to);
    n = 1;
    to = 1'b0;
    while (done !== 1'b1) begin
      if (n >= 3000) begin
        to = 1'b1;
        break;
      end
      @(negedge clock);
      n++;
    end
  endtask

  // ROM responder: checks each request address against the expected sequence
  // and acks it after a random latency, or withholds the ack for one address.
  initial begin
    logic [15:0] ra;
    logic [15:0] re;
    int          rlat;
    int          rw;
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    forever begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (mem_req === 1'b1 && rst === 1'b0) begin
        ra = mem_addr[15:0];
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL addr_seq: unexpected request addr=%h", mem_addr);
        end else begin
          re = exp_addr_q.pop_front();
          if (mem_addr !== {8'h00, re}) begin
            failures++;
            $display("FAIL addr_seq: got addr=%h expected=%h", mem_addr, {8'h00, re});
          end
        end
        if (ra == withhold_addr) begin
          rw = 0;
          while (mem_req === 1'b1 && rw < 400) begin
            @(negedge clock);
            rw++;
          end
        end else begin
          rlat = int'($urandom_range(lat_max, lat_min));
          repeat (rlat) @(negedge clock);
          mem_ack  = 1'b1;
          mem_data = img[ra[8:0]];
          @(negedge clock);
          mem_ack = 1'b0;
        end
      end
    end
  end

  // Verdict monitor: exclusivity every cycle, scoreboard pop on each done.
  initial begin
    exp_t r;
    forever begin
      @(negedge clock);
      checks++;
      if (hdr_ok === 1'b1 && error === 1'b1) begin
        failures++;
        $display("FAIL exclusive: hdr_ok=%b error=%b both high", hdr_ok, error);
      end
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if (res_q.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected: done=1 with no scan expected");
        end else begin
          r = res_q.pop_front();
          if ({hdr_ok, error} !== {r.hdr_ok, r.error}) begin
            failures++;
            $display("FAIL verdict: hdr_ok/error=%b%b expected=%b%b",
                     hdr_ok, error, r.hdr_ok, r.error);
          end
          checks++;
          if ({cart_type, rom_size, ram_size, cgb, mbc_sel} !==
              {r.cart, r.rom, r.ram, r.cgb, r.mbc}) begin
            failures++;
            $display("FAIL fields: type=%h rom=%h ram=%h cgb=%b mbc=%0d expected type=%h rom=%h ram=%h cgb=%b mbc=%0d",
                     cart_type, rom_size, ram_size, cgb, mbc_sel,
                     r.cart, r.rom, r.ram, r.cgb, r.mbc);
          end
          checks++;
          if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_at_done: busy=%b expected=0", busy);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({mem_req, busy, done, hdr_ok, error, cgb} !== 6'b000000) begin
      failures++;
      $display("FAIL %s_ctrl: req/busy/done/ok/err/cgb=%b%b%b%b%b%b expected=000000",
               tag, mem_req, busy, done, hdr_ok, error, cgb);
    end
    checks++;
    if (mem_addr !== 24'h000000) begin
      failures++;
      $display("FAIL %s_addr: mem_addr=%h expected=000000", tag, mem_addr);
    end
    checks++;
    if ({cart_type, rom_size, ram_size, mbc_sel} !== {8'h00, 8'h00, 8'h00, 3'd0}) begin
      failures++;
      $display("FAIL %s_fields: type=%h rom=%h ram=%h mbc=%0d expected all 0",
               tag, cart_type, rom_size, ram_size, mbc_sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_valid_mbc1();
    int n; bit to; int d0;
    lat_min = 0; lat_max = 0;
    build_img(8'h03, 8'h05, 8'h03, 8'h80, 1'b0);
    push_seq('h14D);
    res_q.push_back(exp_from_img(1'b1));
    d0 = done_cnt;
    pulse_start();
    wait_done(n, to);
    checks++;
    if (to) begin failures++; $display("FAIL valid_timeout: no done within %0d cycles", n); end
    checks++;
    if (n !== 54) begin failures++; $display("FAIL valid_latency: cycles=%0d expected=54", n); end
    repeat (3) @(negedge clock);
    checks++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL valid_done_count: got=%0d expected=1", done_cnt - d0); end
    checks++;
    if ({hdr_ok, error, mbc_sel, cgb, rom_size, ram_size} !== {1'b1, 1'b0, 3'd1, 1'b1, 8'h05, 8'h03}) begin
      failures++;
      $display("FAIL valid_held: ok=%b err=%b mbc=%0d cgb=%b rom=%h ram=%h expected 1 0 1 1 05 03",
               hdr_ok, error, mbc_sel, cgb, rom_size, ram_size);
    end
    checks++;
    if (exp_addr_q.size() != 0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL valid_seq_end: left=%0d mem_req=%b expected 0 0", exp_addr_q.size(), mem_req);
    end
  endtask

  task automatic test_bad_checksum();
    int n; bit to; int d0;
    lat_min = 0; lat_max = 1;
    build_img(8'h03, 8'h05, 8'h03, 8'h80, 1'b1);
    push_seq('h14D);
    res_q.push_back(exp_from_img(1'b0));
    d0 = done_cnt;
    pulse_start();
    wait_done(n, to);
    repeat (3) @(negedge clock);
    checks++;
    if (to || done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL badsum_done: timeout=%b count=%0d expected 0 1", to, done_cnt - d0);
    end
    checks++;
    if ({hdr_ok, error, cart_type, rom_size, ram_size, cgb} !== {1'b0, 1'b1, 8'h03, 8'h05, 8'h03, 1'b1}) begin
      failures++;
      $display("FAIL badsum_held: ok=%b err=%b type=%h rom=%h ram=%h cgb=%b expected 0 1 03 05 03 1",
               hdr_ok, error, cart_type, rom_size, ram_size, cgb);
    end
  endtask

  task automatic test_unsupported_type();
    int n; bit to;
    lat_min = 0; lat_max = 0;
    build_img(8'h22, 8'h00, 8'h00, 8'h00, 1'b0);
    push_seq('h14D);
    res_q.push_back(exp_from_img(1'b0));
    pulse_start();
    wait_done(n, to);
    checks++;
    if (to || error !== 1'b1 || hdr_ok !== 1'b0 || mbc_sel !== 3'd7) begin
      failures++;
      $display("FAIL type22: timeout=%b err=%b ok=%b mbc=%0d expected 0 1 0 7", to, error, hdr_ok, mbc_sel);
    end
  endtask

  task automatic test_field_table();
    logic [7:0] tct [12] = '{8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h0F,
                             8'h13, 8'h14, 8'h19, 8'h1E, 8'h1F, 8'h11};
    logic [7:0] trom [12] = '{8'h08, 8'h00, 8'h09, 8'h02, 8'h00, 8'h01,
                              8'h03, 8'h00, 8'h04, 8'h08, 8'h00, 8'h00};
    logic [7:0] tram [12] = '{8'h05, 8'h00, 8'h00, 8'h06, 8'h00, 8'h02,
                              8'h00, 8'h00, 8'h03, 8'h01, 8'h00, 8'h05};
    int n; bit to; bit ok;
    lat_min = 0; lat_max = 2;
    for (int i = 0; i < 12; i++) begin
      ok = (ref_mbc(tct[i]) != 3'd7) && (trom[i] <= 8'h08) && (tram[i] <= 8'h05);
      build_img(tct[i], trom[i], tram[i], 8'($urandom), 1'b0);
      push_seq('h14D);
      res_q.push_back(exp_from_img(ok));
      pulse_start();
      wait_done(n, to);
      checks++;
      if (to || hdr_ok !== ok) begin
        failures++;
        $display("FAIL table[%0d]: type=%h timeout=%b hdr_ok=%b expected=%b", i, tct[i], to, hdr_ok, ok);
      end
    end
  endtask

  task automatic test_timeout();
    int c; exp_t r;
    lat_min = 0; lat_max = 0;
    build_img(8'h01, 8'h00, 8'h00, 8'h80, 1'b0);
    withhold_addr = 16'h013A;
    push_seq('h13A);
    r.hdr_ok = 1'b0; r.error = 1'b1; r.cart = 8'h00; r.rom = 8'h00;
    r.ram = 8'h00; r.cgb = 1'b0; r.mbc = 3'd0;
    res_q.push_back(r);
    pulse_start();
    c = 0;
    while (!(mem_req === 1'b1 && mem_addr === 24'h00013A) && c < 200) begin
      @(negedge clock);
      c++;
    end
    c = 0;
    while (done !== 1'b1 && c < 400) begin
      @(negedge clock);
      c++;
    end
    checks++;
    if (c !== 255) begin failures++; $display("FAIL timeout_cycles: got=%0d expected=255", c); end
    checks++;
    if (mem_req !== 1'b0 || error !== 1'b1) begin
      failures++;
      $display("FAIL timeout_fin: mem_req=%b error=%b expected 0 1", mem_req, error);
    end
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_after: mem_req=%b busy=%b expected 0 0", mem_req, busy);
    end
    withhold_addr = 16'hFFFF;
  endtask

  task automatic test_reset_mid();
    int c; int n; bit to; int d0;
    lat_min = 3; lat_max = 3;
    build_img(8'h01, 8'h02, 8'h01, 8'h00, 1'b0);
    push_seq('h140);
    d0 = done_cnt;
    pulse_start();
    c = 0;
    while (!(mem_req === 1'b1 && mem_addr === 24'h000140) && c < 300) begin
      @(negedge clock);
      c++;
    end
    rst = 1'b1;
    @(negedge clock);
    check_reset_outputs("rstmid");
    rst = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 24'h0 || done_cnt !== d0) begin
      failures++;
      $display("FAIL rstmid_stale_ack: busy=%b req=%b addr=%h dones=%0d expected 0 0 000000 0",
               busy, mem_req, mem_addr, done_cnt - d0);
    end
    lat_min = 0; lat_max = 0;
    push_seq('h14D);
    res_q.push_back(exp_from_img(1'b1));
    pulse_start();
    checks++;
    if (mem_addr !== 24'h000134 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_restart: addr=%h busy=%b expected 000134 1", mem_addr, busy);
    end
    wait_done(n, to);
    checks++;
    if (to || n !== 54) begin failures++; $display("FAIL rstmid_rescan: timeout=%b cycles=%0d expected 0 54", to, n); end
  endtask

  task automatic test_back_to_back();
    int n; bit to; int d0;
    lat_min = 0; lat_max = 20;
    build_img(8'h01, 8'h00, 8'h00, 8'h80, 1'b0);
    push_seq('h14D);
    res_q.push_back(exp_from_img(1'b1));
    d0 = done_cnt;
    pulse_start();
    repeat (30) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(n, to);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL start_in_fin: busy=%b mem_req=%b expected 0 0", busy, mem_req);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (to || done_cnt - d0 !== 1 || exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL midstart: timeout=%b dones=%0d addrs_left=%0d expected 0 1 0",
               to, done_cnt - d0, exp_addr_q.size());
    end
    lat_min = 0; lat_max = 0;
    build_img(8'h13, 8'h01, 8'h01, 8'h00, 1'b1);
    push_seq('h14D);
    res_q.push_back(exp_from_img(1'b0));
    pulse_start();
    checks++;
    if (hdr_ok !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL start_clears: hdr_ok=%b error=%b expected 0 0", hdr_ok, error);
    end
    wait_done(n, to);
    build_img(8'h05, 8'h00, 8'h00, 8'h00, 1'b0);
    push_seq('h14D);
    res_q.push_back(exp_from_img(1'b1));
    pulse_start();
    checks++;
    if (hdr_ok !== 1'b0 || error !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart: hdr_ok=%b error=%b busy=%b expected 0 0 1", hdr_ok, error, busy);
    end
    wait_done(n, to);
    checks++;
    if (to || n !== 54) begin failures++; $display("FAIL b2b_latency: timeout=%b cycles=%0d expected 0 54", to, n); end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_valid_mbc1();
    test_bad_checksum();
    test_unsupported_type();
    test_field_table();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (res_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d verdicts never produced, expected 0", res_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
